// File: rtl/ram_wr_pkg.sv
// ram_wr_pkg: FSM states, AXI encodings and parameter checks shared by the RAM write sequencer
package ram_wr_pkg;
  typedef enum logic [2:0] {IDLE, AW_SEND, W_SEND, B_WAIT, DONE} state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic bit params_ok(input longint unsigned base, input longint unsigned beats,
                                   input longint unsigned bursts);
    return beats >= 64'd1 && beats <= 64'd256 && beats * 64'd4 <= 64'd4096 &&
           bursts >= 64'd1 && base % (beats * 64'd4) == 64'd0;
  endfunction
endpackage

// File: rtl/ram_wr_pattern.sv
// ram_wr_pattern: beat/burst counters producing burst address, write data and last-beat/last-burst flags
module ram_wr_pattern #(
  parameter int AW = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int BEATS = 16,
  parameter int BURSTS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          clear_mode,
  input  logic          beat_adv,
  input  logic          burst_adv,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  output logic          last_beat,
  output logic          last_burst
);
  localparam int BTW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int BUW = BURSTS > 1 ? $clog2(BURSTS) : 1;
  logic [BTW-1:0] beat;
  logic [BUW-1:0] burst;
  assign last_beat = beat == BTW'(BEATS - 1);
  assign last_burst = burst == BUW'(BURSTS - 1);
  assign addr = BASE_ADDR + AW'(64'(burst) * 64'(BEATS) * 64'd4);
  assign wdata = clear_mode ? '0 : 32'(64'(burst) * 64'(BEATS) + 64'(beat));
  always_ff @(posedge clk)
    if (reset || restart) begin
      beat <= '0;
      burst <= '0;
    end else begin
      if (beat_adv) beat <= last_beat ? '0 : beat + BTW'(1);
      if (burst_adv) burst <= burst + BUW'(1);
    end
endmodule

// File: rtl/ram_write_sequencer.sv
// ram_write_sequencer: AXI4 burst RAM fill (zeros or index pattern); define RAM_WR_ABORT_ON_ERR_EN to end a run on the first error response
module ram_write_sequencer
  import ram_wr_pkg::*;
#(
  parameter int AW = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int BEATS = 16,
  parameter int BURSTS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_write,
  input  logic          clear,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic [7:0]    M_AXI_AWLEN,
  output logic [2:0]    M_AXI_AWSIZE,
  output logic [1:0]    M_AXI_AWBURST,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WLAST,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY
);
  localparam bit CFG_OK = params_ok(64'(BASE_ADDR), 64'(BEATS), 64'(BURSTS));
  state_t state, state_nxt;
  logic clear_lat, last_beat, last_burst, start_acc, w_hs, b_hs, b_err, b_stop;
  assign start_acc = state == IDLE && start_write;
  assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs = M_AXI_BREADY && M_AXI_BVALID;
  assign b_err = b_hs && M_AXI_BRESP != RESP_OKAY;
`ifdef RAM_WR_ABORT_ON_ERR_EN
  assign b_stop = last_burst || M_AXI_BRESP != RESP_OKAY;
`else
  assign b_stop = last_burst;
`endif
  ram_wr_pattern #(
    .AW(AW), .BASE_ADDR(BASE_ADDR), .BEATS(BEATS), .BURSTS(BURSTS)
  ) u_pattern (
    .clk(clk),
    .reset(reset),
    .restart(start_acc),
    .clear_mode(clear_lat),
    .beat_adv(w_hs),
    .burst_adv(b_hs && !b_stop),
    .addr(M_AXI_AWADDR),
    .wdata(M_AXI_WDATA),
    .last_beat(last_beat),
    .last_burst(last_burst)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      clear_lat <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        clear_lat <= clear;
        error <= 1'b0;
      end else if (b_err) error <= 1'b1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_write ? AW_SEND : IDLE;
      AW_SEND: state_nxt = M_AXI_AWREADY ? W_SEND : AW_SEND;
      W_SEND:  state_nxt = M_AXI_WREADY && last_beat ? B_WAIT : W_SEND;
      B_WAIT:  state_nxt = M_AXI_BVALID ? (b_stop ? DONE : AW_SEND) : B_WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign M_AXI_AWVALID = state == AW_SEND;
  assign M_AXI_WVALID = state == W_SEND;
  assign M_AXI_BREADY = state == B_WAIT;
  assign M_AXI_WLAST = M_AXI_WVALID && last_beat;
  assign M_AXI_AWLEN = 8'(BEATS - 1);
  assign M_AXI_AWSIZE = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_WSTRB = 4'hF;
  assign busy = M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY;
  assign done = state == DONE;
  always_ff @(posedge clk)
    assert (CFG_OK) else $error("ram_write_sequencer: BASE_ADDR must be BEATS*4 aligned, BEATS 1..256, BURSTS >= 1");
endmodule

// File: tb/tb_ram_write_sequencer.sv
// tb_ram_write_sequencer: randomized scoreboard bench for ram_write_sequencer with a queue-based reference model
module tb_ram_write_sequencer;
  localparam int AW = 32;
  localparam int BEATS = 4;
  localparam int BURSTS = 2;
  localparam logic [31:0] BASE = 32'h1000;
  logic clk = 0, reset = 1, start_write = 0, clear = 0;
  logic busy, done, error;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp = 2'b00;
  logic [3:0] wstrb;
  logic awvalid, wvalid, wlast, bready;
  logic awready = 0, wready = 0, bvalid = 0;
  int n_chk = 0, n_pass = 0;
  bit stall_en = 0;
  logic [31:0] aw_q[$];
  logic [32:0] w_q[$];
  logic [1:0] r_q[$];
  bit aw_st = 0, w_st = 0;
  logic [31:0] aw_hold;
  logic [32:0] w_hold;

  always #5 clk = ~clk;

  ram_write_sequencer #(.AW(AW), .BASE_ADDR(BASE), .BEATS(BEATS), .BURSTS(BURSTS)) dut (
    .clk(clk), .reset(reset), .start_write(start_write), .clear(clear),
    .busy(busy), .done(done), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // slave side: random READY/BVALID, response taken from the head of the expected-response queue
  initial forever begin
    @(posedge clk);
    #1;
    awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    bvalid = bready && (stall_en ? ($urandom_range(0, 2) == 0) : 1'b1);
    bresp = r_q.size() != 0 ? r_q[0] : 2'b00;
  end

  // monitor: pops the scoreboard on every handshake and checks payload stability during stalls
  initial forever begin
    logic [32:0] ew;
    logic [31:0] ea;
    @(negedge clk);
    if (reset) begin
      aw_st = 0;
      w_st = 0;
      continue;
    end
    if (aw_st) begin
      chk("aw_valid_hold", 64'(awvalid), 64'd1);
      chk("aw_addr_hold", 64'(awaddr), 64'(aw_hold));
    end
    if (w_st) begin
      chk("w_valid_hold", 64'(wvalid), 64'd1);
      chk("w_payload_hold", 64'({wlast, wdata}), 64'(w_hold));
    end
    chk("aw_w_exclusive", 64'(awvalid && wvalid), 64'd0);
    if (awvalid && awready) begin
      chk("aw_expected", 64'(aw_q.size() != 0), 64'd1);
      if (aw_q.size() != 0) begin
        ea = aw_q.pop_front();
        chk("awaddr", 64'(awaddr), 64'(ea));
      end
      chk("aw_len_size_burst", 64'({awlen, awsize, awburst}), 64'({8'(BEATS - 1), 3'b010, 2'b01}));
    end
    if (wvalid && wready) begin
      chk("w_expected", 64'(w_q.size() != 0), 64'd1);
      if (w_q.size() != 0) begin
        ew = w_q.pop_front();
        chk("wdata", 64'(wdata), 64'(ew[31:0]));
        chk("wlast", 64'(wlast), 64'(ew[32]));
      end
      chk("wstrb", 64'(wstrb), 64'hF);
    end
    if (bvalid && bready) begin
      chk("b_expected", 64'(r_q.size() != 0), 64'd1);
      if (r_q.size() != 0) void'(r_q.pop_front());
    end
    aw_st = awvalid && !awready;
    aw_hold = awaddr;
    w_st = wvalid && !wready;
    w_hold = {wlast, wdata};
  end

  // reference model: what a run must put on the bus, from the burst/beat arithmetic
  task automatic expect_run(input bit c, input logic [1:0] r0, input logic [1:0] r1,
                            output int issued, output bit exp_err);
    logic [1:0] rt[BURSTS];
    rt[0] = r0;
    rt[1] = r1;
    issued = 0;
    exp_err = 0;
    for (int b = 0; b < BURSTS; b++) begin
      aw_q.push_back(BASE + 32'(b * BEATS * 4));
      for (int k = 0; k < BEATS; k++) w_q.push_back({k == BEATS - 1, c ? 32'h0 : 32'(b * BEATS + k)});
      r_q.push_back(rt[b]);
      issued++;
      exp_err = exp_err | (rt[b] != 2'b00);
`ifdef RAM_WR_ABORT_ON_ERR_EN
      if (rt[b] != 2'b00) break;
`endif
    end
  endtask

  task automatic launch(input bit c);
    @(posedge clk);
    #1;
    clear = c;
    start_write = 1;
    @(posedge clk);
    #1;
    start_write = 0;
    clear = 1'($urandom_range(0, 1));
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("awvalid_after_start", 64'(awvalid), 64'd1);
    chk("error_cleared_on_start", 64'(error), 64'd0);
  endtask

  task automatic run(input bit c, input logic [1:0] r0, input logic [1:0] r1, input bit stalls, input bit poke);
    int issued, n;
    bit exp_err;
    stall_en = stalls;
    expect_run(c, r0, r1, issued, exp_err);
    launch(c);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      start_write = poke && n == 3;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (!stalls) chk("run_cycles", 64'(n), 64'(issued * (BEATS + 2)));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("error_at_done", 64'(error), 64'(exp_err));
    chk("aw_drained", 64'(aw_q.size()), 64'd0);
    chk("w_drained", 64'(w_q.size()), 64'd0);
    chk("b_drained", 64'(r_q.size()), 64'd0);
    start_write = poke;
    @(posedge clk);
    #1;
    start_write = 0;
    chk("idle_after_done", 64'({busy, done, awvalid}), 64'd0);
  endtask

  initial begin
    int n, issued;
    bit exp_err;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", 64'({busy, done, error}), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'(BASE));
    chk("rst_wdata", 64'(wdata), 64'd0);
    reset = 0;
    run(0, 2'b00, 2'b00, 0, 0);
    run(1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) run(1'($urandom_range(0, 1)), 2'b00, 2'b00, 1, 0);
    run(0, 2'b10, 2'b00, 0, 0);
    run(0, 2'b00, 2'b00, 0, 1);
    run(1'($urandom_range(0, 1)), 2'b00, 2'b10, 1, 1);
    run(1'($urandom_range(0, 1)), 2'b11, 2'b00, 1, 0);
    stall_en = 0;
    expect_run(0, 2'b00, 2'b00, issued, exp_err);
    launch(0);
    n = 0;
    while (!wvalid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_w_send", 64'(wvalid), 64'd1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrun_rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'd0);
    chk("midrun_rst_status", 64'({busy, done, error}), 64'd0);
    chk("midrun_rst_payload", 64'({awaddr, wdata}), 64'({BASE, 32'h0}));
    reset = 0;
    aw_q.delete();
    w_q.delete();
    r_q.delete();
    run(0, 2'b00, 2'b00, 0, 0);
    run(1, 2'b00, 2'b00, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
